// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_arbiter_if: request/response handshakes and ALU bus around alu_arbiter.
// Revision 1.0
// ============================================================================
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int FW    = 5
);
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [FW-1:0]    req0_func, req1_func;
  logic             resp0_valid, resp1_valid;
  logic             resp0_ready, resp1_ready;
  logic [WIDTH-1:0] resp0_c, resp1_c;
  logic             resp0_bcond, resp1_bcond;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [FW-1:0]    alu_func;
  logic [WIDTH-1:0] alu_c;
  logic             alu_bcond;

  // master: requesters plus the ALU instance; slave: the arbiter itself
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_func, req1_func, resp0_ready, resp1_ready, alu_c, alu_bcond,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_c, resp1_c,
           resp0_bcond, resp1_bcond, alu_a, alu_b, alu_func
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_func, req1_func, resp0_ready, resp1_ready, alu_c, alu_bcond,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_c, resp1_c,
           resp0_bcond, resp1_bcond, alu_a, alu_b, alu_func
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter: round-robin sharing of one ALU between two requesters.
// Revision 1.0
// ============================================================================
module alu_arbiter #(
  parameter int            WIDTH    = 16,
  parameter int            FW       = 5,
  parameter logic [FW-1:0] ALU_ZERO = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  alu_arbiter_if.slave bus_if
);
  typedef enum logic [0:0] {IDLE = 1'b0, EXEC = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic                   prio_q, prio_d;
  logic                   owner_q, owner_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [FW-1:0]          func_q, func_d;
  logic [1:0]             rv_q, rv_d;
  logic [1:0][WIDTH-1:0]  rc_q, rc_d;
  logic [1:0]             rb_q, rb_d;
  logic [1:0]             grant;
  logic [1:0]             elig;

  // Masking uses the registered valid, so a requester is locked out even in
  // the cycle its response is being consumed.
  assign elig = {bus_if.req1_valid & ~rv_q[1], bus_if.req0_valid & ~rv_q[0]};

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    func_d  = func_q;
    rc_d    = rc_q;
    rb_d    = rb_q;
    grant   = 2'b00;
    rv_d    = rv_q & ~{bus_if.resp1_ready, bus_if.resp0_ready};

    if (state_q == IDLE) begin
      if (elig == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
      else               grant = elig;
      if (grant != 2'b00) begin
        owner_d = grant[1];
        a_d     = grant[1] ? bus_if.req1_a    : bus_if.req0_a;
        b_d     = grant[1] ? bus_if.req1_b    : bus_if.req0_b;
        func_d  = grant[1] ? bus_if.req1_func : bus_if.req0_func;
        prio_d  = ~grant[1];
        state_d = EXEC;
      end
    end else begin
      rv_d[owner_q] = 1'b1;
      rc_d[owner_q] = bus_if.alu_c;
      rb_d[owner_q] = bus_if.alu_bcond;
      state_d       = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= ALU_ZERO;
      rv_q    <= '0;
      rc_q    <= '0;
      rb_q    <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      func_q  <= func_d;
      rv_q    <= rv_d;
      rc_q    <= rc_d;
      rb_q    <= rb_d;
    end
  end

  // FuncCode parks at ALU_ZERO outside EXEC so every op is a visible change
  assign bus_if.alu_a       = (state_q == EXEC) ? a_q    : '0;
  assign bus_if.alu_b       = (state_q == EXEC) ? b_q    : '0;
  assign bus_if.alu_func    = (state_q == EXEC) ? func_q : ALU_ZERO;
  assign bus_if.req0_ready  = grant[0];
  assign bus_if.req1_ready  = grant[1];
  assign bus_if.resp0_valid = rv_q[0];
  assign bus_if.resp1_valid = rv_q[1];
  assign bus_if.resp0_c     = rc_q[0];
  assign bus_if.resp1_c     = rc_q[1];
  assign bus_if.resp0_bcond = rb_q[0];
  assign bus_if.resp1_bcond = rb_q[1];
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter: directed and random stimulus against a transaction model.
// Revision 1.0
// ============================================================================
module tb_alu_arbiter;
  localparam int W  = 16;
  localparam int FW = 5;
  localparam logic [4:0] F_ZERO = 5'd0, F_ADD = 5'd1, F_SUB = 5'd2, F_XOR = 5'd3,
                         F_BEQ = 5'd4, F_BNE = 5'd5, F_BGZ = 5'd6, F_BLZ = 5'd7,
                         F_AND = 5'd8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W), .FW(FW)) bif();

  alu_arbiter #(.WIDTH(W), .FW(FW), .ALU_ZERO(F_ZERO)) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_if (bif.slave)
  );

  function automatic logic [16:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [4:0] f);
    case (f)
      F_ADD:   return {1'b0, 16'(a + b)};
      F_SUB:   return {1'b0, 16'(a - b)};
      F_XOR:   return {1'b0, a ^ b};
      F_AND:   return {1'b0, a & b};
      F_BEQ:   return {a == b, 16'h0000};
      F_BNE:   return {a != b, 16'h0000};
      F_BGZ:   return {$signed(a) > $signed(b), 16'h0000};
      F_BLZ:   return {$signed(a) < $signed(b), 16'h0000};
      default: return 17'h0;
    endcase
  endfunction

  always_comb {bif.alu_bcond, bif.alu_c} = alu_ref(bif.alu_a, bif.alu_b, bif.alu_func);

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  f;
  } op_t;

  op_t         fly[$];
  logic        m_prio;
  logic [1:0]  m_rv;
  logic [1:0]  m_rb;
  logic [15:0] m_rc[2];
  logic [1:0]  m_g;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an op in flight occupies the ALU for exactly the next cycle;
  // grants go to whoever is requesting with no held result, ties to prio.
  task automatic eval();
    logic [1:0] el;
    #1;
    el = {bif.req1_valid & ~m_rv[1], bif.req0_valid & ~m_rv[0]};
    if (fly.size() != 0)  m_g = 2'b00;
    else if (el == 2'b11) m_g = m_prio ? 2'b10 : 2'b01;
    else                  m_g = el;
    check("req0_ready", 32'(bif.req0_ready), 32'(m_g[0]));
    check("req1_ready", 32'(bif.req1_ready), 32'(m_g[1]));
    if (fly.size() != 0) begin
      check("alu_a", 32'(bif.alu_a), 32'(fly[0].a));
      check("alu_b", 32'(bif.alu_b), 32'(fly[0].b));
      check("alu_func", 32'(bif.alu_func), 32'(fly[0].f));
    end else begin
      check("alu_a_idle", 32'(bif.alu_a), 32'h0);
      check("alu_b_idle", 32'(bif.alu_b), 32'h0);
      check("alu_func_idle", 32'(bif.alu_func), 32'(F_ZERO));
    end
    check("resp0_valid", 32'(bif.resp0_valid), 32'(m_rv[0]));
    check("resp1_valid", 32'(bif.resp1_valid), 32'(m_rv[1]));
    if (m_rv[0]) begin
      check("resp0_c", 32'(bif.resp0_c), 32'(m_rc[0]));
      check("resp0_bcond", 32'(bif.resp0_bcond), 32'(m_rb[0]));
    end
    if (m_rv[1]) begin
      check("resp1_c", 32'(bif.resp1_c), 32'(m_rc[1]));
      check("resp1_bcond", 32'(bif.resp1_bcond), 32'(m_rb[1]));
    end
  endtask

  task automatic adv();
    logic [16:0] r;
    op_t         o;
    if (!reset_n) begin
      fly.delete();
      m_prio = 1'b0;
      m_rv   = 2'b00;
      m_rb   = 2'b00;
      m_rc[0] = 16'h0;
      m_rc[1] = 16'h0;
    end else begin
      if (bif.resp0_ready) m_rv[0] = 1'b0;
      if (bif.resp1_ready) m_rv[1] = 1'b0;
      if (fly.size() != 0) begin
        o = fly.pop_front();
        r = alu_ref(o.a, o.b, o.f);
        m_rc[o.id] = r[15:0];
        m_rb[o.id] = r[16];
        m_rv[o.id] = 1'b1;
      end else if (m_g != 2'b00) begin
        o.id = m_g[1];
        o.a  = m_g[1] ? bif.req1_a    : bif.req0_a;
        o.b  = m_g[1] ? bif.req1_b    : bif.req0_b;
        o.f  = m_g[1] ? bif.req1_func : bif.req0_func;
        fly.push_back(o);
        m_prio = ~m_g[1];
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    eval();
    adv();
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic [4:0] f);
    if (i == 0) begin
      bif.req0_valid = v; bif.req0_a = a; bif.req0_b = b; bif.req0_func = f;
    end else begin
      bif.req1_valid = v; bif.req1_a = a; bif.req1_b = b; bif.req1_func = f;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic branch_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] f, input logic exp_bc);
    set_req(0, 1'b1, a, b, f);
    eval();
    check({nm, "_accept"}, 32'(bif.req0_ready), 32'd1);
    adv();
    bif.req0_valid = 1'b0;
    tick();
    eval();
    check({nm, "_bcond"}, 32'(bif.resp0_bcond), 32'(exp_bc));
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    set_req(0, 1'b0, 16'h0, 16'h0, F_ZERO);
    set_req(1, 1'b0, 16'h0, 16'h0, F_ZERO);
    bif.resp0_ready = 1'b1;
    bif.resp1_ready = 1'b1;
    m_g = 2'b00;
    @(negedge clk);
    adv();
    adv();
    reset_n = 1'b1;

    // Reset values
    eval();
    check("rst_alu_func", 32'(bif.alu_func), 32'(F_ZERO));
    check("rst_alu_a", 32'(bif.alu_a), 32'h0);
    check("rst_resp0_valid", 32'(bif.resp0_valid), 32'h0);
    check("rst_resp1_valid", 32'(bif.resp1_valid), 32'h0);
    check("rst_resp0_c", 32'(bif.resp0_c), 32'h0);
    check("rst_resp1_c", 32'(bif.resp1_c), 32'h0);
    check("rst_resp_bcond", 32'({bif.resp1_bcond, bif.resp0_bcond}), 32'h0);
    adv();

    // Single op: 5 + 3
    set_req(0, 1'b1, 16'h0005, 16'h0003, F_ADD);
    eval();
    check("single_ready_T", 32'(bif.req0_ready), 32'd1);
    check("single_func_T", 32'(bif.alu_func), 32'(F_ZERO));
    adv();
    bif.req0_valid = 1'b0;
    eval();
    check("single_func_T1", 32'(bif.alu_func), 32'(F_ADD));
    adv();
    eval();
    check("single_valid_T2", 32'(bif.resp0_valid), 32'd1);
    check("single_c_T2", 32'(bif.resp0_c), 32'h0008);
    check("single_func_T2", 32'(bif.alu_func), 32'(F_ZERO));
    adv();

    // Round-robin with both requesters always valid
    do_reset();
    set_req(0, 1'b1, 16'h0010, 16'h0001, F_SUB);
    set_req(1, 1'b1, 16'h00FF, 16'h0F0F, F_XOR);
    for (int k = 0; k < 8; k++) begin
      eval();
      check("rr_grant0", 32'(bif.req0_ready), 32'((k == 0) || (k == 4)));
      check("rr_grant1", 32'(bif.req1_ready), 32'((k == 2) || (k == 6)));
      if (k == 2) check("rr_resp0_c", 32'(bif.resp0_c), 32'h000F);
      if (k == 4) check("rr_resp1_c", 32'(bif.resp1_c), 32'h0FF0);
      adv();
    end
    set_req(0, 1'b0, 16'h0, 16'h0, F_ZERO);
    set_req(1, 1'b0, 16'h0, 16'h0, F_ZERO);
    repeat (3) tick();

    // Backpressure on requester 0 while requester 1 keeps working
    do_reset();
    set_req(0, 1'b1, 16'h0100, 16'h0023, F_ADD);
    set_req(1, 1'b1, 16'h0050, 16'h0010, F_SUB);
    for (int k = 0; k < 9; k++) begin
      bif.resp0_ready = !((k >= 2) && (k <= 6));
      eval();
      if (k == 0) check("bp_first_grant", 32'(bif.req0_ready), 32'd1);
      if (k >= 1 && k <= 7) check("bp_req0_blocked", 32'(bif.req0_ready), 32'd0);
      if (k >= 2 && k <= 7) begin
        check("bp_resp0_c_hold", 32'(bif.resp0_c), 32'h0123);
        check("bp_resp0_valid_hold", 32'(bif.resp0_valid), 32'd1);
      end
      if (k == 2) check("bp_req1_granted", 32'(bif.req1_ready), 32'd1);
      if (k == 8) check("bp_req0_eligible", 32'(bif.req0_ready), 32'd1);
      adv();
    end
    bif.resp0_ready = 1'b1;
    set_req(0, 1'b0, 16'h0, 16'h0, F_ZERO);
    set_req(1, 1'b0, 16'h0, 16'h0, F_ZERO);
    repeat (3) tick();

    // Branch flags
    do_reset();
    branch_op("beq", 16'h1234, 16'h1234, F_BEQ, 1'b1);
    branch_op("blz", 16'h0000, 16'h0001, F_BLZ, 1'b1);
    branch_op("bgz", 16'h0000, 16'h0001, F_BGZ, 1'b0);

    // Reset in the middle of an op
    do_reset();
    set_req(1, 1'b1, 16'h1111, 16'h2222, F_ADD);
    eval();
    check("midrst_accept1", 32'(bif.req1_ready), 32'd1);
    adv();
    bif.req1_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    set_req(0, 1'b1, 16'h0001, 16'h0001, F_ADD);
    set_req(1, 1'b1, 16'h0002, 16'h0002, F_ADD);
    eval();
    check("midrst_resp1_valid", 32'(bif.resp1_valid), 32'd0);
    check("midrst_alu_func", 32'(bif.alu_func), 32'(F_ZERO));
    check("midrst_alu_a", 32'(bif.alu_a), 32'h0);
    check("midrst_resp1_c", 32'(bif.resp1_c), 32'h0);
    check("midrst_grant0", 32'(bif.req0_ready), 32'd1);
    adv();
    set_req(0, 1'b0, 16'h0, 16'h0, F_ZERO);
    set_req(1, 1'b0, 16'h0, 16'h0, F_ZERO);
    repeat (4) tick();

    // Idle: prio is 1 after the req0 grant above and must survive idling
    for (int k = 0; k < 10; k++) begin
      eval();
      check("idle_func", 32'(bif.alu_func), 32'(F_ZERO));
      check("idle_ready", 32'({bif.req1_ready, bif.req0_ready}), 32'h0);
      adv();
    end
    set_req(0, 1'b1, 16'h0003, 16'h0004, F_AND);
    set_req(1, 1'b1, 16'h0007, 16'h0001, F_SUB);
    eval();
    check("idle_prio_kept", 32'({bif.req1_ready, bif.req0_ready}), 32'h2);
    adv();
    set_req(0, 1'b0, 16'h0, 16'h0, F_ZERO);
    set_req(1, 1'b0, 16'h0, 16'h0, F_ZERO);
    repeat (3) tick();

    // Random traffic with backpressure, withdrawn requests and stray resets
    for (int k = 0; k < 800; k++) begin
      reset_n = ($urandom_range(0, 63) != 0);
      set_req(0, ($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
              5'($urandom_range(0, 31)));
      set_req(1, ($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
              5'($urandom_range(0, 31)));
      bif.resp0_ready = ($urandom_range(0, 9) < 6);
      bif.resp1_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
